// File: rtl/level_regenerator.sv
// level_regenerator: rebuilds a glitch-free level from rise/fall request pulses,
// holding every transition for at least HOLD_CYC cycles and buffering one reversal.
module level_regenerator #(
  parameter int   HOLD_CYC   = 4,
  parameter int   CNT_W      = 8,
  parameter logic INIT_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rise_req,
  input  logic fall_req,
  output logic level_out,
  output logic busy,
  output logic pending,
  output logic cancel_pulse,
  output logic conflict_pulse
);
  typedef enum logic {STABLE, HOLD} state_t;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYC - 1);
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic level_nx, pend_valid, pend_nx, pend_lvl, pend_lvl_nx, cancel_nx, conflict_nx;
  logic req, t, want, ret, tog;
  always_comb begin
    req = rise_req ^ fall_req;
    t = rise_req;
    want = req && (t != level_out);
    ret = req && (t == level_out) && pend_valid;
    conflict_nx = rise_req & fall_req;
    cancel_nx = 1'b0;
    tog = 1'b0;
    state_nx = state;
    cnt_nx = cnt;
    level_nx = level_out;
    pend_nx = pend_valid;
    pend_lvl_nx = pend_lvl;
    if (state == STABLE) begin
      tog = want;
    end else begin
      cancel_nx = ret;
      if (cnt != '0) begin
        cnt_nx = cnt - 1'b1;
        if (want) begin
          pend_nx = 1'b1;
          pend_lvl_nx = t;
        end else if (ret) begin
          pend_nx = 1'b0;
        end
      end else begin
        // decision cycle: a surviving pending entry or a fresh opposite request toggles
        tog = (pend_valid && !ret && (pend_lvl != level_out)) || want;
        pend_nx = 1'b0;
        state_nx = tog ? HOLD : STABLE;
      end
    end
    if (tog) begin
      level_nx = ~level_out;
      cnt_nx = RELOAD;
      state_nx = HOLD;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= STABLE;
      cnt <= '0;
      level_out <= INIT_LEVEL;
      pend_valid <= 1'b0;
      pend_lvl <= 1'b0;
      cancel_pulse <= 1'b0;
      conflict_pulse <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      level_out <= level_nx;
      pend_valid <= pend_nx;
      pend_lvl <= pend_lvl_nx;
      cancel_pulse <= cancel_nx;
      conflict_pulse <= conflict_nx;
    end
  end
  assign busy = (state == HOLD);
  assign pending = pend_valid;
endmodule

// File: tb/tb_level_regenerator.sv
// tb_level_regenerator: directed scenarios plus a time-based reference model
// (transitions allowed only HOLD cycles after the previous one) checked every cycle.
module tb_level_regenerator;
  localparam int HOLD = 4;
  logic clk = 1'b0, rst_n = 1'b0, rise_req = 1'b0, fall_req = 1'b0;
  logic level_out, busy, pending, cancel_pulse, conflict_pulse;
  int checks = 0, passed = 0;
  bit run = 1'b0;
  bit m_level = 1'b0, m_pend = 1'b0, m_cancel = 1'b0, m_conflict = 1'b0;
  int n = 0, m_last = -1000;

  level_regenerator #(.HOLD_CYC(HOLD), .CNT_W(8), .INIT_LEVEL(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .rise_req(rise_req), .fall_req(fall_req),
    .level_out(level_out), .busy(busy), .pending(pending),
    .cancel_pulse(cancel_pulse), .conflict_pulse(conflict_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic got, input logic exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s at %0t: got %b expected %b", nm, $time, got, exp);
  endtask

  // model: edge index e, last transition edge m_last; hold window is e - m_last < HOLD
  always @(posedge clk or negedge rst_n) begin : model
    logic req, t, ret, want, tog, open;
    int e;
    if (!rst_n) begin
      m_level <= 1'b0;
      m_pend <= 1'b0;
      m_cancel <= 1'b0;
      m_conflict <= 1'b0;
      m_last <= -1000;
    end else begin
      e = n + 1;
      req = rise_req ^ fall_req;
      t = rise_req;
      ret = req && (t == m_level) && m_pend;
      want = req && (t != m_level);
      open = (e - m_last) >= HOLD;
      tog = open && ((m_pend && !ret) || want);
      n <= e;
      m_conflict <= rise_req & fall_req;
      m_cancel <= ret;
      if (open) m_pend <= 1'b0;
      else if (want) m_pend <= 1'b1;
      else if (ret) m_pend <= 1'b0;
      if (tog) begin
        m_level <= ~m_level;
        m_last <= e;
      end
    end
  end

  always @(negedge clk) if (run) begin
    chk("model_level", level_out, m_level);
    chk("model_busy", busy, (n - m_last) < HOLD);
    chk("model_pending", pending, m_pend);
    chk("model_cancel", cancel_pulse, m_cancel);
    chk("model_conflict", conflict_pulse, m_conflict);
  end

  task automatic cyc(input logic r, input logic f);
    rise_req = r;
    fall_req = f;
    @(negedge clk);
    rise_req = 1'b0;
    fall_req = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) cyc(1'b0, 1'b0);
  endtask

  task automatic lbp(input string nm, input logic l, input logic b, input logic p);
    chk({nm, "_level"}, level_out, l);
    chk({nm, "_busy"}, busy, b);
    chk({nm, "_pending"}, pending, p);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    lbp("reset", 1'b0, 1'b0, 1'b0);
    chk("reset_cancel", cancel_pulse, 1'b0);
    chk("reset_conflict", conflict_pulse, 1'b0);
    rst_n = 1'b1;
    run = 1'b1;
    idle(2);
    // basic rise
    cyc(1'b1, 1'b0); lbp("rise_e0", 1'b1, 1'b1, 1'b0);
    idle(3);         lbp("rise_e3", 1'b1, 1'b1, 1'b0);
    idle(1);         lbp("rise_e4", 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1); idle(4); lbp("back_low", 1'b0, 1'b0, 1'b0);
    // minimum width enforced
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1); lbp("minw_e1", 1'b1, 1'b1, 1'b1);
    idle(2);         lbp("minw_e3", 1'b1, 1'b1, 1'b1);
    idle(1);         lbp("minw_e4", 1'b0, 1'b1, 1'b0);
    idle(3);         lbp("minw_e7", 1'b0, 1'b1, 1'b0);
    idle(1);         lbp("minw_e8", 1'b0, 1'b0, 1'b0);
    // glitch cancel
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1); chk("glitch_pend", pending, 1'b1);
    cyc(1'b1, 1'b0); chk("glitch_cancel", cancel_pulse, 1'b1); lbp("glitch_e2", 1'b1, 1'b1, 1'b0);
    idle(1);         chk("glitch_cancel_off", cancel_pulse, 1'b0);
    idle(1);         lbp("glitch_e4", 1'b1, 1'b0, 1'b0);
    idle(3);         lbp("glitch_quiet", 1'b1, 1'b0, 1'b0);
    // conflict and redundancy
    cyc(1'b0, 1'b1); idle(4);
    cyc(1'b1, 1'b1); chk("conflict_pulse", conflict_pulse, 1'b1); lbp("conflict", 1'b0, 1'b0, 1'b0);
    idle(1);         chk("conflict_off", conflict_pulse, 1'b0);
    cyc(1'b1, 1'b0); idle(4);
    cyc(1'b1, 1'b0); lbp("redundant", 1'b1, 1'b0, 1'b0);
    chk("redundant_cancel", cancel_pulse, 1'b0);
    chk("redundant_conflict", conflict_pulse, 1'b0);
    // request landing exactly in the decision cycle
    cyc(1'b0, 1'b1); idle(4);
    cyc(1'b1, 1'b0); idle(3);
    cyc(1'b0, 1'b1); lbp("decide_e4", 1'b0, 1'b1, 1'b0);
    idle(3);         lbp("decide_e7", 1'b0, 1'b1, 1'b0);
    idle(1);         lbp("decide_e8", 1'b0, 1'b0, 1'b0);
    // cancel arriving in the decision cycle
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1); idle(2);
    cyc(1'b1, 1'b0); chk("dcancel_pulse", cancel_pulse, 1'b1); lbp("dcancel", 1'b1, 1'b0, 1'b0);
    // reset mid-hold with a pending transition
    cyc(1'b0, 1'b1); idle(4);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1 lbp("rst_mid", 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    idle(5);         lbp("rst_after", 1'b0, 1'b0, 1'b0);
    // mixed traffic against the model
    repeat (300) begin
      int r;
      r = $urandom_range(0, 7);
      cyc(r == 0 || r == 2, r == 1 || r == 2);
    end
    idle(6);
    run = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/level_regenerator.md
Name: level_regenerator

Overview:
- Inverse of the team's edge detector: rebuilds a clean level signal from single-cycle rise/fall request pulses.
- Enforces a minimum stable time after every transition, so the output is glitch-free.
- Buffers at most one opposite-direction request during the hold window. A return request inside the window cancels it.
- Sits on the transmit side of pulse-based control links. It drives pads or a downstream clock domain that needs guaranteed minimum high/low widths.

Parameters:
- HOLD_CYC, 4: minimum cycles level_out stays stable after any transition; legal range 1..2^CNT_W.
- CNT_W, 8: hold counter width.
- INIT_LEVEL, 0: level_out value in reset.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- rise_req  input  1  single-cycle request to drive level_out high; synchronous to clk.
- fall_req  input  1  single-cycle request to drive level_out low; synchronous to clk.
- level_out  output  1  regenerated level, registered.
- busy  output  1  high while in HOLD state (minimum-width window active).
- pending  output  1  a buffered transition is waiting for the hold window to end.
- cancel_pulse  output  1  one-cycle pulse: a pending transition was cancelled by a return request.
- conflict_pulse  output  1  one-cycle pulse: rise_req and fall_req asserted in the same cycle.

Behaviour:
- Reset (async assert, sync deassert use):
  - level_out=INIT_LEVEL; state=STABLE; cnt=0.
  - pend_valid=0, pend_lvl=0.
  - busy, pending, cancel_pulse and conflict_pulse all 0.
- Request decode, each cycle:
  - t=1 if only rise_req; t=0 if only fall_req; no request if neither.
  - Both set: request ignored, conflict_pulse=1 next cycle, no state change.
- STABLE state:
  - Request with t!=level_out: level_out<=t at that edge (latency 1), cnt<=HOLD_CYC-1, state<=HOLD.
  - Request with t==level_out: redundant, ignored, no flags.
- HOLD state, cnt!=0:
  - cnt decrements each cycle.
  - t!=level_out: pend_valid<=1, pend_lvl<=t.
  - t==level_out with pend_valid=1: pend_valid<=0, cancel_pulse=1.
  - t==level_out with pend_valid=0: ignored.
- HOLD state, cnt==0 (decision cycle):
  - Effective request = pending entry merged with the same-cycle request, using the rules above.
  - Effective request != level_out: level_out toggles, cnt<=HOLD_CYC-1, stay HOLD, pend_valid<=0.
  - Otherwise: state<=STABLE, pend_valid<=0.
  - Cancel in the decision cycle (pending present plus a return request) still pulses cancel_pulse.
- Guarantee: after a transition at edge E, the next transition is no earlier than edge E+HOLD_CYC.
- HOLD_CYC=1: the decision happens every cycle, so behaviour equals STABLE with one-cycle latency.
- Output mapping: busy=(state==HOLD); pending=pend_valid. Both are registered or decoded from registers; no combinational path from inputs.
- cancel_pulse and conflict_pulse are registered, high exactly one cycle per event.
- Reset mid-HOLD: everything returns to reset values immediately. The pending transition is discarded and never replayed after release.
- Counter arithmetic is unsigned CNT_W bits. HOLD_CYC-1 must fit in CNT_W; no wrap is permitted.

Test Plan:
- Basic rise, HOLD_CYC=4, INIT_LEVEL=0:
  - Stimulus: rise_req pulse sampled at edge E.
  - Required: level_out=1 after E; busy=1 after edges E..E+3; busy=0 after E+4; pending=0 throughout.
- Minimum width enforced:
  - Stimulus: rise at E, fall at E+1.
  - Required: pending=1 from E+1; level_out falls exactly at E+4 (high 4 cycles); busy re-asserts for 4 more cycles; pending clears at E+4.
- Glitch cancel:
  - Stimulus: rise at E, fall at E+1, rise at E+2.
  - Required: cancel_pulse=1 for one cycle after E+2; pending=0; level_out stays 1; busy=0 after E+4; no further transition.
- Conflict and redundancy:
  - Stimulus: rise_req=fall_req=1 in STABLE with level 0.
  - Required: conflict_pulse one cycle, level_out stays 0.
  - Stimulus: later rise_req while level_out=1 and STABLE.
  - Required: no change, no flags.
- Decision-cycle request:
  - Stimulus: rise at E, no pending, fall_req exactly at E+4.
  - Required: level_out falls at E+4 and a new 4-cycle hold starts.
- Reset mid-operation:
  - Stimulus: rise at E, fall at E+1, rst_n low at E+2 for 2 cycles.
  - Required: level_out=0, busy=0, pending=0 immediately on reset assert; no edge after release until a new request.
